// File: rtl/pbl_pkg.sv
// Shared types and defaults for the program-counter / return-stack block.
// The action decode shared by the RTL lives here as a helper function.
package pbl_pkg;

  localparam int PC_WIDTH_DEF    = 5;
  localparam int STACK_DEPTH_DEF = 8;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SEQ  = 2'd0,
    JUMP = 2'd1,
    CALL = 2'd2,
    RET  = 2'd3
  } action_e;

  // RET beats CALL beats JUMP; a partial call/return strobe set falls through to SEQ.
  function automatic action_e decode_action(input logic jmp, input logic cal,
                                            input logic ret, input logic push,
                                            input logic pop);
    action_e act;
    if (ret && pop) begin
      act = RET;
    end else if (cal && push && jmp) begin
      act = CALL;
    end else if (jmp) begin
      act = JUMP;
    end else begin
      act = SEQ;
    end
    return act;
  endfunction

endpackage

// File: rtl/pc_stack_if.sv
// Decoder-to-sequencer bundle: control strobes and branch target in, pc and stack status out.
interface pc_stack_if #(
  parameter int PC_WIDTH = pbl_pkg::PC_WIDTH_DEF
);
  logic                en;
  logic                jmp;
  logic                cal;
  logic                ret;
  logic                push;
  logic                pop;
  logic [PC_WIDTH-1:0] jmp_addr;
  logic [PC_WIDTH-1:0] pc;
  logic                stack_full;
  logic                stack_empty;
  logic                stack_err;
  logic                halted;

  modport master (
    output en, jmp, cal, ret, push, pop, jmp_addr,
    input  pc, stack_full, stack_empty, stack_err, halted
  );

  modport slave (
    input  en, jmp, cal, ret, push, pop, jmp_addr,
    output pc, stack_full, stack_empty, stack_err, halted
  );
endinterface

// File: rtl/pc_stack_call_stack.sv
// Return-address LIFO with registered full/empty flags; storage is not reset.
module call_stack
  import pbl_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH_DEF,
  parameter int DEPTH = STACK_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int AW = PW - 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    ptr_r;
  logic             full_r;
  logic             empty_r;
  logic [PW-1:0]    ptr_nxt_s;
  logic [AW-1:0]    wr_idx_s;
  logic [AW-1:0]    top_idx_s;
  logic             do_push_s;

  // Next occupancy; pushes into a full stack and pops from an empty one are dropped.
  always_comb begin
    ptr_nxt_s = ptr_r;
    do_push_s = push && !full_r;
    if (do_push_s) begin
      ptr_nxt_s = ptr_r + PW'(1'b1);
    end else if (pop && !empty_r) begin
      ptr_nxt_s = ptr_r - PW'(1'b1);
    end else begin
      ptr_nxt_s = ptr_r;
    end
    wr_idx_s  = ptr_r[AW-1:0];
    top_idx_s = ptr_r[AW-1:0] - AW'(1'b1);
  end

  // Storage write; contents are only meaningful below the pointer.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_idx_s] <= data_in;
    end
  end

  // Pointer and flags, registered together so they agree with occupancy every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r   <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      ptr_r   <= ptr_nxt_s;
      full_r  <= (ptr_nxt_s == PW'(DEPTH));
      empty_r <= (ptr_nxt_s == '0);
    end
  end

  assign data_out = mem_r[top_idx_s];
  assign full     = full_r;
  assign empty    = empty_r;

endmodule

// File: rtl/pc_stack.sv
// Program counter with call/return stack and RUN/HALT control.
// Build option: define PC_STACK_ERR_HALT_EN to halt on stack overflow/underflow.
module pc_stack
  import pbl_pkg::*;
#(
  parameter int PC_WIDTH    = PC_WIDTH_DEF,
  parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
  input logic     clk,
  input logic     rst,
  pc_stack_if.slave bus
);

  state_e              state_r;
  logic [PC_WIDTH-1:0] pc_r;
  logic                err_r;
  action_e             action_s;
  logic                advance_s;
  logic                push_s;
  logic                pop_s;
  logic                full_s;
  logic                empty_s;
  logic [PC_WIDTH-1:0] top_s;
  logic [PC_WIDTH-1:0] pc_inc_s;
`ifdef PC_STACK_ERR_HALT_EN
  logic                halted_r;
`endif

  // Decode the strobes and derive the stack requests for this cycle.
  always_comb begin
    action_s  = decode_action(bus.jmp, bus.cal, bus.ret, bus.push, bus.pop);
    pc_inc_s  = pc_r + PC_WIDTH'(1'b1);
    advance_s = (state_r == RUN) && bus.en;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    if (advance_s) begin
      case (action_s)
        CALL:    push_s = !full_s;
        RET:     pop_s  = !empty_s;
        default: begin
          push_s = 1'b0;
          pop_s  = 1'b0;
        end
      endcase
    end else begin
      push_s = 1'b0;
      pop_s  = 1'b0;
    end
  end

  call_stack #(
    .WIDTH (PC_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_call_stack (
    .clk      (clk),
    .rst      (rst),
    .push     (push_s),
    .pop      (pop_s),
    .data_in  (pc_inc_s),
    .data_out (top_s),
    .full     (full_s),
    .empty    (empty_s)
  );

  // RUN/HALT state machine owning pc and the sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= RUN;
      pc_r     <= '0;
      err_r    <= 1'b0;
`ifdef PC_STACK_ERR_HALT_EN
      halted_r <= 1'b0;
`endif
    end else if (advance_s) begin
      case (action_s)
        RET: begin
          if (empty_s) begin
            err_r    <= 1'b1;
`ifdef PC_STACK_ERR_HALT_EN
            state_r  <= HALT;
            halted_r <= 1'b1;
`else
            pc_r     <= '0;
`endif
          end else begin
            pc_r <= top_s;
          end
        end
        CALL: begin
          if (full_s) begin
            err_r    <= 1'b1;
`ifdef PC_STACK_ERR_HALT_EN
            state_r  <= HALT;
            halted_r <= 1'b1;
`else
            // Overflow still branches; only the return address is lost.
            pc_r     <= bus.jmp_addr;
`endif
          end else begin
            pc_r <= bus.jmp_addr;
          end
        end
        JUMP:    pc_r <= bus.jmp_addr;
        SEQ:     pc_r <= pc_inc_s;
        default: pc_r <= pc_inc_s;
      endcase
    end
  end

  assign bus.pc          = pc_r;
  assign bus.stack_full  = full_s;
  assign bus.stack_empty = empty_s;
  assign bus.stack_err   = err_r;
`ifdef PC_STACK_ERR_HALT_EN
  assign bus.halted      = halted_r;
`else
  assign bus.halted      = 1'b0;
`endif

endmodule

// File: tb/tb_pc_stack.sv
// Self-checking bench for pc_stack: vector table for nested calls plus directed corner sequences.
// Expectations follow PC_STACK_ERR_HALT_EN when the bench is built with it.
module tb_pc_stack;

  localparam int PW = 5;
  localparam int SD = 8;
`ifdef PC_STACK_ERR_HALT_EN
  localparam logic HM = 1'b1;
`else
  localparam logic HM = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  pc_stack_if #(.PC_WIDTH(PW)) bus ();

  pc_stack #(
    .PC_WIDTH    (PW),
    .STACK_DEPTH (SD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [8:0] exp;
  } sb_t;

  typedef struct {
    logic       jmp;
    logic       cal;
    logic       ret;
    logic       push;
    logic       pop;
    logic [4:0] addr;
    logic [4:0] pc;
    logic       full;
    logic       empty;
  } vec_t;

  sb_t  sb_q[$];
  vec_t tbl[16];

  function automatic logic [8:0] pack(input logic [4:0] p, input logic f, input logic e,
                                      input logic er, input logic h);
    return {p, f, e, er, h};
  endfunction

  function automatic logic [8:0] dut_o();
    return {bus.pc, bus.stack_full, bus.stack_empty, bus.stack_err, bus.halted};
  endfunction

  task automatic check(input string nm, input logic [8:0] act, input logic [8:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got pc=%0d full=%b empty=%b err=%b halted=%b, expected pc=%0d full=%b empty=%b err=%b halted=%b",
               nm, act[8:4], act[3], act[2], act[1], act[0],
               exp[8:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic drive(input logic e, input logic j, input logic c, input logic r,
                       input logic pu, input logic po, input logic [4:0] a);
    bus.en       = e;
    bus.jmp      = j;
    bus.cal      = c;
    bus.ret      = r;
    bus.push     = pu;
    bus.pop      = po;
    bus.jmp_addr = a;
  endtask

  // Drive one cycle, queue its expectation, then compare just after the edge.
  task automatic step(input string nm, input logic e, input logic j, input logic c,
                      input logic r, input logic pu, input logic po,
                      input logic [4:0] a, input logic [8:0] exp);
    sb_t s;
    drive(e, j, c, r, pu, po, a);
    sb_q.push_back('{name: nm, exp: exp});
    @(posedge clk);
    #1;
    s = sb_q.pop_front();
    check(s.name, dut_o(), s.exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 8; k++) begin
      tbl[k].jmp    = 1'b1;
      tbl[k].cal    = 1'b1;
      tbl[k].ret    = 1'b0;
      tbl[k].push   = 1'b1;
      tbl[k].pop    = 1'b0;
      tbl[k].addr   = 5'(10 + k);
      tbl[k].pc     = 5'(10 + k);
      tbl[k].full   = (k == 7);
      tbl[k].empty  = 1'b0;
      tbl[8+k].jmp   = 1'b0;
      tbl[8+k].cal   = 1'b0;
      tbl[8+k].ret   = 1'b1;
      tbl[8+k].push  = 1'b0;
      tbl[8+k].pop   = 1'b1;
      tbl[8+k].addr  = 5'd0;
      tbl[8+k].pc    = (k < 7) ? 5'(17 - k) : 5'd5;
      tbl[8+k].full  = 1'b0;
      tbl[8+k].empty = (k == 7);
    end

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    #2;
    check("reset_state", dut_o(), pack(5'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Sequential run through the wrap.
    for (int k = 1; k <= 33; k++) begin
      step($sformatf("seq_%0d", k), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,
           pack(5'(k % 32), 1'b0, 1'b1, 1'b0, 1'b0));
    end
    step("seq_to_2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, pack(5'd2, 1'b0, 1'b1, 1'b0, 1'b0));
    step("seq_to_3", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, pack(5'd3, 1'b0, 1'b1, 1'b0, 1'b0));

    step("call_20", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd20, pack(5'd20, 1'b0, 1'b0, 1'b0, 1'b0));
    step("run_21", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, pack(5'd21, 1'b0, 1'b0, 1'b0, 1'b0));
    step("run_22", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, pack(5'd22, 1'b0, 1'b0, 1'b0, 1'b0));
    step("ret_4", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, pack(5'd4, 1'b0, 1'b1, 1'b0, 1'b0));

    // Eight nested calls followed by eight returns in LIFO order.
    for (int k = 0; k < 16; k++) begin
      step($sformatf("nest_%0d", k), 1'b1, tbl[k].jmp, tbl[k].cal, tbl[k].ret,
           tbl[k].push, tbl[k].pop, tbl[k].addr,
           pack(tbl[k].pc, tbl[k].full, tbl[k].empty, 1'b0, 1'b0));
    end

    step("seq_to_6", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, pack(5'd6, 1'b0, 1'b1, 1'b0, 1'b0));
    step("seq_to_7", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, pack(5'd7, 1'b0, 1'b1, 1'b0, 1'b0));
    step("underflow", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0,
         pack(HM ? 5'd7 : 5'd0, 1'b0, 1'b1, 1'b1, HM));
    step("post_underflow_jmp", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd9,
         pack(HM ? 5'd7 : 5'd9, 1'b0, 1'b1, 1'b1, HM));

    // Asynchronous reset between edges.
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", dut_o(), pack(5'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    step("pri_call", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd20, pack(5'd20, 1'b0, 1'b0, 1'b0, 1'b0));
    step("pri_all", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd25, pack(5'd1, 1'b0, 1'b1, 1'b0, 1'b0));
    step("en0_jmp", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd9, pack(5'd1, 1'b0, 1'b1, 1'b0, 1'b0));
    step("en0_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, pack(5'd1, 1'b0, 1'b1, 1'b0, 1'b0));

    for (int k = 0; k < 8; k++) begin
      step($sformatf("fill_%0d", k), 1'b1, tbl[k].jmp, tbl[k].cal, tbl[k].ret,
           tbl[k].push, tbl[k].pop, tbl[k].addr,
           pack(tbl[k].pc, tbl[k].full, tbl[k].empty, 1'b0, 1'b0));
    end
    step("overflow", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd5,
         pack(HM ? 5'd17 : 5'd5, 1'b1, 1'b0, 1'b1, HM));
    step("post_overflow_ret", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0,
         pack(5'd17, HM, 1'b0, 1'b1, HM));

    // Reset landing on a pending CALL; the held strobes run from pc=0 after release.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd12);
    rst = 1'b1;
    #1;
    check("reset_mid_call", dut_o(), pack(5'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    check("reset_held", dut_o(), pack(5'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    rst = 1'b0;
    step("first_after_reset", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd12,
         pack(5'd12, 1'b0, 1'b0, 1'b0, 1'b0));
    step("ret_after_reset", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0,
         pack(5'd1, 1'b0, 1'b1, 1'b0, 1'b0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_stack.md
PC_STACK -- requirements
Module: pc_stack

Interface
REQ-001 The block SHALL have parameter PC_WIDTH, default 5, meaning program-counter and jump-address width.
REQ-002 The block SHALL have parameter STACK_DEPTH, default 8, meaning number of return-address entries (power of two, >=2).
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, meaning asynchronous active-high reset.
REQ-005 The block SHALL have port en, input, 1, meaning advance enable; when 0, all state holds.
REQ-006 The block SHALL have ports jmp, cal, ret, push and pop, each input, 1, meaning control strobes from the instruction decoder.
REQ-007 The block SHALL have port jmp_addr, input, PC_WIDTH, meaning the branch/call target.
REQ-008 The block SHALL have port pc, output, PC_WIDTH, meaning the registered address of the current instruction.
REQ-009 The block SHALL have ports stack_full and stack_empty, each output, 1, meaning stack occupancy = STACK_DEPTH and occupancy = 0 respectively.
REQ-010 The block SHALL have port stack_err, output, 1, meaning a sticky overflow/underflow flag.
REQ-011 The block SHALL have port halted, output, 1, meaning the FSM is in HALT.

Function
REQ-012 FSM states SHALL be RUN and HALT; HALT SHALL be left only by reset.
REQ-013 In RUN with en=1, the next action SHALL be chosen by priority: RET (ret&pop) > CALL (cal&push&jmp) > JUMP (jmp) > SEQ.
- RET: pc <= top of stack; pop.
- CALL: push (pc+1) mod 2^PC_WIDTH; pc <= jmp_addr.
- JUMP: pc <= jmp_addr.
- SEQ: pc <= (pc+1) mod 2^PC_WIDTH.
REQ-014 Any other combination of push/pop/cal/ret SHALL be treated as SEQ, with no stack change.
REQ-015 Latency SHALL be one cycle: the action decoded in cycle N SHALL be visible on pc in cycle N+1.
REQ-016 The PC SHALL wrap from 2^PC_WIDTH-1 to 0 without any flag.
REQ-017 The return address SHALL wrap identically, so a CALL at pc=31 (PC_WIDTH=5) pushes 0.
REQ-018 stack_full and stack_empty SHALL be registered and consistent with occupancy in the same cycle as pc.
REQ-019 Overflow (CALL while stack_full) and underflow (RET while stack_empty) SHALL set stack_err=1, which holds until reset.
REQ-020 Overflow and underflow SHALL leave stack contents unchanged; the pc behaviour is per REQ-025/REQ-026.
REQ-021 In HALT, pc, the stack, and all flags SHALL hold regardless of en or the strobes.

Reset
REQ-022 While rst=1, outputs SHALL immediately be: pc=0, stack_empty=1, stack_full=0, stack_err=0, halted=0.
REQ-023 While rst=1, the FSM SHALL be RUN and occupancy SHALL be 0; stack RAM contents need not be cleared.
REQ-024 Reset asserted mid-CALL or mid-RET SHALL discard the pending action; the first edge after release with en=1 SHALL execute the then-present strobes from pc=0.

Configuration
REQ-025 With macro PC_STACK_ERR_HALT_EN defined, overflow and underflow SHALL set stack_err, transition to HALT, and freeze pc at its current value.
REQ-026 Without PC_STACK_ERR_HALT_EN, overflow SHALL set stack_err and take the jump while dropping the push, and underflow SHALL set stack_err and set pc <= 0; the FSM SHALL stay in RUN and halted SHALL remain tied 0.

Structure
REQ-027 A shared package pbl_pkg SHALL hold the FSM state typedef (RUN, HALT), the action enum (SEQ, JUMP, CALL, RET) and default PC_WIDTH and STACK_DEPTH constants.
REQ-028 The LIFO SHALL be a sub-module call_stack (push/pop/data_in/data_out/full/empty, pointer of clog2(STACK_DEPTH)+1 bits); the PC register and FSM SHALL stay in pc_stack.

Verification
REQ-029 Scenario SEQ: reset, then en=1 with no strobes for 33 cycles -> pc runs 0..31, wraps to 0, then reaches 1.
REQ-030 Scenario CALL/RET: at pc=3, CALL with jmp_addr=20 -> next pc=20 and stack_empty=0; run 2 cycles, then RET -> pc=4 and stack_empty=1.
REQ-031 Scenario nested/full: 8 CALLs with targets 10..17 -> stack_full=1; 8 RETs -> pcs returned in LIFO order and stack_empty=1.
REQ-032 Scenario overflow, 9th CALL with target 5: with the macro defined -> stack_err=1, halted=1, pc frozen, and strobes ignored; without it -> pc=5, stack_err=1, occupancy remains 8.
REQ-033 Scenario underflow, RET on an empty stack at pc=7: with the macro defined -> halted=1 and pc=7; without it -> pc=0 and stack_err=1.
REQ-034 Scenario priority/reset: ret&pop&jmp&cal&push asserted together -> RET is taken; rst pulsed mid-sequence -> outputs reset immediately without a clock edge, and en=0 holds pc.
